// File: rtl/multi_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : multi_timer
// Brief    : Memory-mapped multi-channel down-counting timer with a shared
//            prescaler, per-channel reload/one-shot modes and sticky IRQ flags.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module multi_timer #(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = 32,
  parameter int PRESCALE_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren,
  input  logic              wen,
  input  logic [7:0]        address,
  input  logic [31:0]       data_in,
  input  logic [3:0]        byte_select,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam logic [5:0] PRESCALE_WORD = 6'h20;
  localparam logic [5:0] PENDING_WORD  = 6'h21;

  logic [5:0]               addr_word;
  logic [2:0]               ch_sel;
  logic [1:0]               reg_sel;
  logic                     chan_hit;
  logic                     wr_pre;
  logic                     tick;
  logic [31:0]              lane_mask;
  logic [PRESCALE_BITS-1:0] prescale;
  logic [PRESCALE_BITS-1:0] pcnt;
  logic                     unused_addr_bits;

  logic [NUM_CH-1:0] en_v;
  logic [NUM_CH-1:0] ar_v;
  logic [NUM_CH-1:0] ie_v;
  logic [NUM_CH-1:0] flag_v;
  logic [WIDTH-1:0]  count_rd  [NUM_CH];
  logic [WIDTH-1:0]  reload_rd [NUM_CH];

  assign unused_addr_bits = ^address[1:0];
  assign addr_word = address[7:2];
  assign ch_sel    = address[6:4];
  assign reg_sel   = address[3:2];
  assign chan_hit  = !address[7] && (int'(ch_sel) < NUM_CH);
  assign wr_pre    = wen && (addr_word == PRESCALE_WORD);
  assign lane_mask = {{8{byte_select[3]}}, {8{byte_select[2]}},
                      {8{byte_select[1]}}, {8{byte_select[0]}}};

  // A PRESCALE write restarts the divider and swallows the tick of that edge.
  assign tick = (pcnt == prescale) && !wr_pre;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_pre)
        prescale <= (prescale & ~lane_mask[PRESCALE_BITS-1:0]) |
                    (data_in[PRESCALE_BITS-1:0] & lane_mask[PRESCALE_BITS-1:0]);
      if (wr_pre || pcnt >= prescale)
        pcnt <= '0;
      else
        pcnt <= pcnt + PRESCALE_BITS'(1);
    end
  end

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic             sel;
      logic             wr_ctrl;
      logic             wr_reload;
      logic             wr_count;
      logic             wr_status;
      logic             expire;
      logic             en;
      logic             auto_reload;
      logic             irq_en;
      logic             flag;
      logic [WIDTH-1:0] count;
      logic [WIDTH-1:0] reload;

      assign sel       = wen && chan_hit && (ch_sel == 3'(c));
      assign wr_ctrl   = sel && (reg_sel == 2'd0) && byte_select[0];
      assign wr_reload = sel && (reg_sel == 2'd1);
      assign wr_count  = sel && (reg_sel == 2'd2);
      assign wr_status = sel && (reg_sel == 2'd3) && byte_select[0] && data_in[0];
      assign expire    = en && tick && (count == '0);

      always_ff @(posedge clk) begin
        if (!reset) begin
          en          <= 1'b0;
          auto_reload <= 1'b0;
          irq_en      <= 1'b0;
          flag        <= 1'b0;
          count       <= '0;
          reload      <= '0;
        end else begin
          if (wr_reload)
            reload <= (reload & ~lane_mask[WIDTH-1:0]) | (data_in[WIDTH-1:0] & lane_mask[WIDTH-1:0]);

          // CPU writes win over the hardware count update on the same edge.
          if (wr_count)
            count <= (count & ~lane_mask[WIDTH-1:0]) | (data_in[WIDTH-1:0] & lane_mask[WIDTH-1:0]);
          else if (en && tick)
            count <= (count != '0) ? count - WIDTH'(1) : (auto_reload ? reload : '0);

          if (wr_ctrl) begin
            en          <= data_in[0];
            auto_reload <= data_in[1];
            irq_en      <= data_in[2];
          end else if (expire && !auto_reload) begin
            en <= 1'b0;
          end

          if (expire)
            flag <= 1'b1;
          else if (wr_status)
            flag <= 1'b0;
        end
      end

      assign en_v[c]      = en;
      assign ar_v[c]      = auto_reload;
      assign ie_v[c]      = irq_en;
      assign flag_v[c]    = flag;
      assign count_rd[c]  = count;
      assign reload_rd[c] = reload;
    end
  endgenerate

  assign irq     = flag_v & ie_v;
  assign irq_any = |irq;

  always_comb begin
    data_out = '0;
    if (ren) begin
      if (addr_word == PRESCALE_WORD) begin
        data_out = 32'(prescale);
      end else if (addr_word == PENDING_WORD) begin
        data_out = 32'(flag_v);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (chan_hit && (ch_sel == 3'(i))) begin
            case (reg_sel)
              2'd0:    data_out = {29'b0, ie_v[i], ar_v[i], en_v[i]};
              2'd1:    data_out = 32'(reload_rd[i]);
              2'd2:    data_out = 32'(count_rd[i]);
              default: data_out = {31'b0, flag_v[i]};
            endcase
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_multi_timer
// Brief    : Directed self-checking bench for multi_timer with a reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multi_timer;

  localparam int NUM_CH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ren = 1'b0;
  logic              wen = 1'b0;
  logic [7:0]        address = '0;
  logic [31:0]       data_in = '0;
  logic [3:0]        byte_select = '0;
  logic [31:0]       data_out;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multi_timer #(.NUM_CH(NUM_CH), .WIDTH(32), .PRESCALE_BITS(16)) dut (
    .clk(clk), .reset(reset), .ren(ren), .wen(wen), .address(address),
    .data_in(data_in), .byte_select(byte_select), .data_out(data_out),
    .irq(irq), .irq_any(irq_any)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: registers as plain integers, prescaler as elapsed-edge arithmetic.
  bit          m_en[NUM_CH], m_ar[NUM_CH], m_ie[NUM_CH], m_flag[NUM_CH];
  int unsigned m_reload[NUM_CH], m_count[NUM_CH];
  int unsigned m_pre = 0;
  int unsigned m_k = 0;
  bit          go = 0;

  function automatic int unsigned lanes(input int unsigned old, input int unsigned d,
                                        input logic [3:0] bs);
    int unsigned r = old;
    for (int b = 0; b < 4; b++)
      if (bs[b]) r = (r & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
    return r;
  endfunction

  function automatic int unsigned mread(input logic [7:0] a);
    int w  = int'(a[7:2]);
    int ch = int'(a[6:4]);
    int rg = int'(a[3:2]);
    int unsigned pend = 0;
    if (w == 32) return m_pre;
    if (w == 33) begin
      for (int i = 0; i < NUM_CH; i++) if (m_flag[i]) pend |= (1 << i);
      return pend;
    end
    if (w < 32 && ch < NUM_CH) begin
      case (rg)
        0: return (m_ie[ch] ? 4 : 0) + (m_ar[ch] ? 2 : 0) + (m_en[ch] ? 1 : 0);
        1: return m_reload[ch];
        2: return m_count[ch];
        default: return m_flag[ch] ? 1 : 0;
      endcase
    end
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int  w, ch, rg;
    bit  pre_wr, tk, hit, fired;
    w      = int'(address[7:2]);
    ch     = int'(address[6:4]);
    rg     = int'(address[3:2]);
    pre_wr = wen && (w == 32);
    tk     = !pre_wr && ((m_k % (m_pre + 1)) == m_pre);
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_en[i] = 0; m_ar[i] = 0; m_ie[i] = 0; m_flag[i] = 0;
        m_reload[i] = 0; m_count[i] = 0;
      end
      m_pre = 0;
      m_k   = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hit   = wen && (w < 32) && (ch == i);
        fired = m_en[i] && tk && (m_count[i] == 0);
        if (hit && rg == 2) m_count[i] = lanes(m_count[i], data_in, byte_select);
        else if (m_en[i] && tk) m_count[i] = (m_count[i] > 0) ? m_count[i] - 1 : (m_ar[i] ? m_reload[i] : 0);
        if (hit && rg == 1) m_reload[i] = lanes(m_reload[i], data_in, byte_select);
        if (hit && rg == 0 && byte_select[0]) begin
          m_en[i] = data_in[0]; m_ar[i] = data_in[1]; m_ie[i] = data_in[2];
        end else if (fired && !m_ar[i]) m_en[i] = 0;
        if (fired) m_flag[i] = 1;
        else if (hit && rg == 3 && byte_select[0] && data_in[0]) m_flag[i] = 0;
      end
      if (pre_wr) begin
        m_pre = lanes(m_pre, data_in, byte_select) & 32'hFFFF;
        m_k   = 0;
      end else m_k++;
    end
    go = 1;
  end

  always @(negedge clk) begin
    logic [NUM_CH-1:0] mi;
    if (go) begin
      for (int i = 0; i < NUM_CH; i++) mi[i] = m_flag[i] & m_ie[i];
      chk("irq", 32'(irq), 32'(mi));
      chk("irq_any", 32'(irq_any), 32'(|mi));
      chk("rdata", data_out, ren ? mread(address) : 32'h0);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] bs);
    ren = 0; wen = 1; address = a; data_in = d; byte_select = bs;
    @(posedge clk); #1;
    wen = 0; byte_select = '0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    wen = 0; ren = 1; address = a;
    #2 chk(name, data_out, exp);
    @(posedge clk); #1;
    ren = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_irq_any", 32'(irq_any), 32'h0);
    reset = 1;
    rd(8'h00, 32'h0, "rst_ctrl0");
    rd(8'h08, 32'h0, "rst_count0");
    rd(8'h80, 32'h0, "rst_prescale");

    // Auto-reload, period 4 with PRESCALE=0
    wr(8'h80, 32'h0, 4'hF);
    wr(8'h04, 32'h3, 4'hF);
    wr(8'h08, 32'h3, 4'hF);
    wr(8'h00, 32'h7, 4'hF);
    idle(3);
    chk("t1_irq_before", 32'(irq[0]), 32'h0);
    idle(1);
    chk("t1_irq_4th_edge", 32'(irq[0]), 32'h1);
    rd(8'h08, 32'h3, "t1_reloaded");
    wr(8'h0C, 32'h1, 4'hF);
    chk("t1_w1c_drop", 32'(irq[0]), 32'h0);
    idle(1);
    chk("t1_still_low", 32'(irq[0]), 32'h0);
    idle(1);
    chk("t1_second_expiry", 32'(irq[0]), 32'h1);
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h0C, 32'h1, 4'hF);

    // One-shot with PRESCALE=4
    wr(8'h18, 32'h2, 4'hF);
    wr(8'h80, 32'h4, 4'hF);
    wr(8'h10, 32'h5, 4'hF);
    idle(13);
    rd(8'h1C, 32'h0, "t2_flag_before");
    rd(8'h1C, 32'h1, "t2_flag_set");
    chk("t2_irq1", 32'(irq[1]), 32'h1);
    rd(8'h10, 32'h4, "t2_ctrl_en_clr");
    rd(8'h18, 32'h0, "t2_count_zero");
    idle(10);
    rd(8'h18, 32'h0, "t2_count_holds");
    rd(8'h10, 32'h4, "t2_ctrl_holds");
    wr(8'h80, 32'h0, 4'hF);
    wr(8'h1C, 32'h1, 4'hF);

    // W1C collides with a hardware expiry
    wr(8'h24, 32'h0, 4'hF);
    wr(8'h28, 32'h0, 4'hF);
    wr(8'h20, 32'h7, 4'hF);
    wr(8'h2C, 32'h1, 4'hF);
    rd(8'h2C, 32'h1, "t3_set_beats_clear");
    wr(8'h20, 32'h4, 4'hF);
    wr(8'h2C, 32'h1, 4'hF);
    rd(8'h2C, 32'h0, "t3_clear");
    chk("t3_irq2_low", 32'(irq[2]), 32'h0);

    // CPU COUNT write beats decrement; byte-lane write
    wr(8'h38, 32'h5, 4'hF);
    wr(8'h30, 32'h1, 4'hF);
    wr(8'h38, 32'h10, 4'h1);
    rd(8'h38, 32'h10, "t4_write_wins");
    wr(8'h30, 32'h0, 4'hF);
    wr(8'h38, 32'hFFFF_AB00, 4'h2);
    rd(8'h38, 32'hAB0E, "t4_byte_lane");
    wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    rd(8'h40, 32'h0, "unmapped_ch4_ctrl");
    rd(8'h48, 32'h0, "unmapped_ch4_count");

    // All channels, reloads 1..4, started together by the PRESCALE write
    for (int c = 0; c < NUM_CH; c++) begin
      wr(8'(c * 16 + 4), 32'(c + 1), 4'hF);
      wr(8'(c * 16 + 8), 32'(c + 1), 4'hF);
    end
    wr(8'h80, 32'd1000, 4'hF);
    for (int c = 0; c < NUM_CH; c++) wr(8'(c * 16), 32'h7, 4'hF);
    wr(8'h80, 32'h0, 4'hF);
    rd(8'h84, 32'h0, "t5_pend_a");
    rd(8'h84, 32'h0, "t5_pend_b");
    rd(8'h84, 32'h1, "t5_pend_c");
    rd(8'h84, 32'h3, "t5_pend_d");
    rd(8'h84, 32'h7, "t5_pend_e");
    rd(8'h84, 32'hF, "t5_pend_f");
    idle(50);
    rd(8'h84, 32'hF, "t5_pend_lcm");
    chk("t5_irq_all", 32'(irq), 32'hF);
    chk("t5_irq_any", 32'(irq_any), 32'h1);

    // Reset mid-count
    wr(8'h00, 32'h4, 4'hF);
    wr(8'h08, 32'h7, 4'hF);
    rd(8'h08, 32'h7, "t6_count_before");
    rd(8'h0C, 32'h1, "t6_flag_before");
    reset = 0;
    @(posedge clk); #1;
    chk("t6_irq", 32'(irq), 32'h0);
    chk("t6_irq_any", 32'(irq_any), 32'h0);
    reset = 1;
    rd(8'h00, 32'h0, "t6_ctrl");
    rd(8'h08, 32'h0, "t6_count");
    rd(8'h0C, 32'h0, "t6_flag");
    rd(8'h34, 32'h0, "t6_reload3");
    rd(8'h80, 32'h0, "t6_prescale");
    rd(8'h84, 32'h0, "t6_pending");
    rd(8'h90, 32'h0, "t6_unmapped_90");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
